// File: rtl/phase_gen_pkg.sv
// Shared types and constants for the two-phase clock generator.
package phase_gen_pkg;

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_PHI1 = 3'd1,
    S_GAP1 = 3'd2,
    S_PHI2 = 3'd3,
    S_GAP2 = 3'd4
  } phase_state_e;

  localparam int CYCLE_W = 16;

  // Largest of three values; sizes the shared state-timing counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_gen.sv
// Two-phase non-overlapping PHI1/PHI2 enable generator with dead gaps,
// post-reset hold, PHI1 stall stretching, strobes and a PHI1 cycle counter.
module phase_gen
  import phase_gen_pkg::*;
#(
  parameter int DIV      = 12,
  parameter int GAP      = 1,
  parameter int RST_HOLD = 4
) (
  input  logic               CLK,
  input  logic               n_RES,
  input  logic               STALL,
  output logic               PHI1,
  output logic               PHI2,
  output logic               PHI1_START,
  output logic               PHI2_END,
  output logic [CYCLE_W-1:0] CYCLE
);

  localparam int H     = DIV / 2 - GAP;
  localparam int CNT_W = $clog2(max3(H, GAP, RST_HOLD) + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(RST_HOLD);

  // Parameter sanity checks at elaboration.
  if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
    $error("phase_gen: DIV must be even and >= 4");
  end
  if (GAP < 1 || GAP >= DIV / 2) begin : g_bad_gap
    $error("phase_gen: GAP must satisfy 1 <= GAP < DIV/2");
  end
  if (RST_HOLD < 1) begin : g_bad_hold
    $error("phase_gen: RST_HOLD must be >= 1");
  end

  phase_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phi1_q, phi1_d;
  logic               phi2_q, phi2_d;
  logic               phi1_start_q, phi1_start_d;
  logic               phi2_end_q, phi2_end_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               last;

  // Next state: one down-counter times every state; it reloads on each
  // transition and parks at 1 while a PHI1 stall is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last    = (cnt_q == CNT_ONE);
    case (state_q)
      S_HOLD: begin
        if (last) begin state_d = S_PHI1; cnt_d = CNT_H; end
        else      cnt_d = cnt_q - CNT_ONE;
      end
      S_PHI1: begin
        if (last) begin
          if (!STALL) begin state_d = S_GAP1; cnt_d = CNT_GAP; end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP1: begin
        if (last) begin state_d = S_PHI2; cnt_d = CNT_H; end
        else      cnt_d = cnt_q - CNT_ONE;
      end
      S_PHI2: begin
        if (last) begin state_d = S_GAP2; cnt_d = CNT_GAP; end
        else      cnt_d = cnt_q - CNT_ONE;
      end
      S_GAP2: begin
        if (last) begin state_d = S_PHI1; cnt_d = CNT_H; end
        else      cnt_d = cnt_q - CNT_ONE;
      end
      default: begin state_d = S_HOLD; cnt_d = CNT_HOLD; end
    endcase
  end

  // Outputs decoded from the next state so every output is a plain flop.
  always_comb begin
    phi1_d       = (state_d == S_PHI1);
    phi2_d       = (state_d == S_PHI2);
    phi1_start_d = (state_d == S_PHI1) && (state_q != S_PHI1);
    phi2_end_d   = (state_d == S_PHI2) && (cnt_d == CNT_ONE);
    cycle_d      = phi1_start_d ? cycle_q + CYCLE_W'(1) : cycle_q;
  end

  // State, counter and output registers; reset clears enables at once.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q      <= S_HOLD;
      cnt_q        <= CNT_HOLD;
      phi1_q       <= 1'b0;
      phi2_q       <= 1'b0;
      phi1_start_q <= 1'b0;
      phi2_end_q   <= 1'b0;
      cycle_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phi1_q       <= phi1_d;
      phi2_q       <= phi2_d;
      phi1_start_q <= phi1_start_d;
      phi2_end_q   <= phi2_end_d;
      cycle_q      <= cycle_d;
    end
  end

  assign PHI1       = phi1_q;
  assign PHI2       = phi2_q;
  assign PHI1_START = phi1_start_q;
  assign PHI2_END   = phi2_end_q;
  assign CYCLE      = cycle_q;

endmodule

// File: tb/tb_phase_gen.sv
// Scoreboard bench for phase_gen: stimulus pushes per-cycle expected outputs,
// monitors pop and compare one entry after every rising CLK edge.
module tb_phase_gen;

  localparam int H_A = 5, G_A = 1, HOLD_A = 4;
  localparam int H_B = 2, G_B = 2, HOLD_B = 4;

  typedef struct packed {
    logic        p1;
    logic        p2;
    logic        st;
    logic        en;
    logic [15:0] cyc;
  } exp_t;

  logic        clk;
  logic        rst_a, stall_a, rst_b, stall_b;
  logic        phi1_a, phi2_a, st_a, en_a;
  logic        phi1_b, phi2_b, st_b, en_b;
  logic [15:0] cycle_a, cycle_b;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [15:0] cyc_a, cyc_b;
  int n_cmp, n_err;
  bit done_b;

  phase_gen #(.DIV(12), .GAP(1), .RST_HOLD(4)) dut_a (
    .CLK(clk), .n_RES(rst_a), .STALL(stall_a),
    .PHI1(phi1_a), .PHI2(phi2_a), .PHI1_START(st_a), .PHI2_END(en_a),
    .CYCLE(cycle_a)
  );

  phase_gen #(.DIV(8), .GAP(2), .RST_HOLD(4)) dut_b (
    .CLK(clk), .n_RES(rst_b), .STALL(stall_b),
    .PHI1(phi1_b), .PHI2(phi2_b), .PHI1_START(st_b), .PHI2_END(en_b),
    .CYCLE(cycle_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic p1, input logic p2, input logic st,
                              input logic en, input logic [15:0] c);
    exp_t e;
    e.p1 = p1; e.p2 = p2; e.st = st; e.en = en; e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // ---------------- instance A stimulus helpers ----------------
  task automatic step_a(input logic s, input logic r, input exp_t e);
    @(negedge clk);
    stall_a = s;
    rst_a   = r;
    qa.push_back(e);
  endtask

  task automatic phi1_win_a(input int k);
    cyc_a = cyc_a + 16'd1;
    for (int i = 0; i < H_A + k; i++)
      step_a(i >= H_A, 1'b1, mk(1'b1, 1'b0, i == 0, 1'b0, cyc_a));
  endtask

  task automatic gap_a();
    for (int i = 0; i < G_A; i++) step_a(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, cyc_a));
  endtask

  task automatic phi2_win_a(input bit poke_stall, input int n);
    for (int i = 0; i < n; i++)
      step_a(poke_stall && (i == 2), 1'b1, mk(1'b0, 1'b1, 1'b0, i == H_A - 1, cyc_a));
  endtask

  task automatic period_a(input int k, input bit poke_stall);
    phi1_win_a(k);
    gap_a();
    phi2_win_a(poke_stall, H_A);
    gap_a();
  endtask

  task automatic release_a();
    for (int i = 0; i < HOLD_A - 1; i++) step_a(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
  endtask

  // ---------------- instance B stimulus helpers ----------------
  task automatic step_b(input logic r, input exp_t e);
    @(negedge clk);
    stall_b = 1'b0;
    rst_b   = r;
    qb.push_back(e);
  endtask

  task automatic period_b();
    cyc_b = cyc_b + 16'd1;
    for (int i = 0; i < H_B; i++) step_b(1'b1, mk(1'b1, 1'b0, i == 0, 1'b0, cyc_b));
    for (int i = 0; i < G_B; i++) step_b(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, cyc_b));
    for (int i = 0; i < H_B; i++) step_b(1'b1, mk(1'b0, 1'b1, 1'b0, i == H_B - 1, cyc_b));
    for (int i = 0; i < G_B; i++) step_b(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, cyc_b));
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_outputs", {12'd0, phi1_a, phi2_a, st_a, en_a, cycle_a}, {12'd0, ea});
      chk("a_no_overlap", {31'd0, phi1_a & phi2_a}, 32'd0);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_outputs", {12'd0, phi1_b, phi2_b, st_b, en_b, cycle_b}, {12'd0, eb});
      chk("b_no_overlap", {31'd0, phi1_b & phi2_b}, 32'd0);
    end
  end

  // Watchdog: the run is a fixed number of cycles, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t run did not complete", $time);
    $fatal(1, "watchdog expired");
  end

  // Instance B: DIV=8, GAP=2 gives a 2/2/2/2 pattern.
  initial begin
    done_b  = 1'b0;
    rst_b   = 1'b0;
    stall_b = 1'b0;
    cyc_b   = 16'd0;
    step_b(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    step_b(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < HOLD_B - 1; i++) step_b(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    repeat (3) period_b();
    done_b = 1'b1;
  end

  // Instance A: main directed sequence.
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_a   = 1'b0;
    stall_a = 1'b0;
    cyc_a   = 16'd0;

    // Reset state held for two edges, then release and hold.
    step_a(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    step_a(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    release_a();

    // Three unstalled 12-cycle periods, CYCLE 1..3.
    repeat (3) period_a(0, 1'b0);

    // STALL for three samples: 8-cycle PHI1, 15-cycle period, then 12 again.
    period_a(3, 1'b0);
    period_a(0, 1'b0);

    // STALL pulsed inside PHI2 has no effect.
    period_a(0, 1'b1);

    // Reset asserted in the third PHI2 cycle drops PHI2 without an edge.
    phi1_win_a(0);
    gap_a();
    phi2_win_a(1'b0, 2);
    cyc_a = 16'd0;
    step_a(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    #1;
    chk("async_phi2_low", {31'd0, phi2_a}, 32'd0);
    chk("async_phi1_low", {31'd0, phi1_a}, 32'd0);
    chk("async_cycle_zero", {16'd0, cycle_a}, 32'd0);
    step_a(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    release_a();
    period_a(0, 1'b0);

    // CYCLE wrap: preload 0xFFFF in the final gap, next start reads 0.
    phi1_win_a(0);
    gap_a();
    phi2_win_a(1'b0, H_A);
    cyc_a = 16'hFFFF;
    gap_a();
    force dut_a.cycle_q = 16'hFFFF;
    #1;
    release dut_a.cycle_q;
    period_a(0, 1'b0);
    period_a(0, 1'b0);

    // Let the monitors drain, then confirm nothing was left unchecked.
    wait (done_b == 1'b1);
    @(posedge clk);
    #3;
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
